// File: rtl/imm_field_encoder_pkg.sv
// Shared definitions for the immediate field encoder: format codes, select
// encodings and the signed range limits each format must respect.
package imm_field_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_I     = 3'd0,
        FMT_SHAMT = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_J     = 3'd4,
        FMT_U     = 3'd5
    } fmt_e;

    // Selects are ordered {type3, type2, type} to match the decode side.
    localparam logic [2:0] SEL_IS    = 3'b000;
    localparam logic [2:0] SEL_SHAMT = 3'b001;
    localparam logic [2:0] SEL_B     = 3'b010;
    localparam logic [2:0] SEL_J     = 3'b011;
    localparam logic [2:0] SEL_U     = 3'b100;

    localparam int IS_MIN    = -2048;
    localparam int IS_MAX    = 2047;
    localparam int SHAMT_MIN = 0;
    localparam int SHAMT_MAX = 31;
    localparam int B_MIN     = -4096;
    localparam int B_MAX     = 4094;
    localparam int J_MIN     = -1048576;
    localparam int J_MAX     = 1048574;

    function automatic logic in_range(logic signed [31:0] v, int lo, int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/imm_field_encoder_range_check.sv
// Combinational legality check of an immediate against its format's signed
// range and alignment rules; unknown formats are always illegal.
module imm_range_check
    import imm_field_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic        err
);

    logic signed [31:0] simm;
    fmt_e               fmt_code;

    assign simm     = $signed(imm);
    assign fmt_code = fmt_e'(fmt);

    always_comb begin
        err = 1'b1;
        case (fmt_code)
            FMT_I, FMT_S: err = !in_range(simm, IS_MIN, IS_MAX);
            FMT_SHAMT:    err = !in_range(simm, SHAMT_MIN, SHAMT_MAX);
            FMT_B:        err = !in_range(simm, B_MIN, B_MAX) || imm[0];
            FMT_J:        err = !in_range(simm, J_MIN, J_MAX) || imm[0];
            FMT_U:        err = (imm[11:0] != 12'd0);
            default:      err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_field_encoder.sv
// Two-stage valid/ready encoder: S1 registers the checked immediate, S2 holds
// the packed field and selects. Also keeps transfer and error statistics.
module imm_field_encoder
    import imm_field_encoder_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [19:0]       out_field,
    output logic              out_type,
    output logic              out_type2,
    output logic              out_type3,
    output logic              out_err,
    output logic              err_sticky,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  enc_count,
    output logic [ERR_W-1:0]  err_count
);

    logic        ready_en;
    logic        s1_v;
    logic [2:0]  s1_fmt;
    logic [31:0] s1_imm;
    logic        s1_err;
    logic        s2_v;
    logic [2:0]  out_sel;
    logic        chk_err;
    logic        s2_adv;
    logic [19:0] pk_field;
    logic [2:0]  pk_sel;

    imm_range_check u_range_check (
        .fmt (in_fmt),
        .imm (in_imm),
        .err (chk_err)
    );

    // ready_en keeps in_ready low until the first clock after reset releases.
    assign s2_adv    = !s2_v || out_ready;
    assign in_ready  = ready_en && (!s1_v || s2_adv);
    assign out_valid = s2_v;
    assign out_type  = out_sel[0];
    assign out_type2 = out_sel[1];
    assign out_type3 = out_sel[2];

    always_comb begin
        pk_field = '0;
        pk_sel   = SEL_IS;
        if (!s1_err) begin
            case (fmt_e'(s1_fmt))
                FMT_I, FMT_S: begin pk_field[11:0] = s1_imm[11:0]; pk_sel = SEL_IS;    end
                FMT_SHAMT:    begin pk_field[4:0]  = s1_imm[4:0];  pk_sel = SEL_SHAMT; end
                FMT_B:        begin pk_field[11:0] = s1_imm[12:1]; pk_sel = SEL_B;     end
                FMT_J:        begin pk_field       = s1_imm[20:1]; pk_sel = SEL_J;     end
                FMT_U:        begin pk_field       = s1_imm[31:12]; pk_sel = SEL_U;    end
                default:      begin pk_field       = '0;           pk_sel = SEL_IS;    end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en   <= 1'b0;
            s1_v       <= 1'b0;
            s1_fmt     <= '0;
            s1_imm     <= '0;
            s1_err     <= 1'b0;
            s2_v       <= 1'b0;
            out_field  <= '0;
            out_sel    <= '0;
            out_err    <= 1'b0;
            err_sticky <= 1'b0;
            enc_count  <= '0;
            err_count  <= '0;
        end else begin
            ready_en <= 1'b1;

            // S2 only reloads when empty or draining, so a stalled result stays put.
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    out_field <= pk_field;
                    out_sel   <= pk_sel;
                    out_err   <= s1_err;
                end
            end

            if (in_ready) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_fmt <= in_fmt;
                    s1_imm <= in_imm;
                    s1_err <= chk_err;
                end
            end

            if (clr_stats) begin
                enc_count  <= '0;
                err_count  <= '0;
                err_sticky <= 1'b0;
            end else if (s2_v && out_ready) begin
                enc_count <= enc_count + CNT_W'(1);
                if (out_err) begin
                    err_sticky <= 1'b1;
                    if (err_count != {ERR_W{1'b1}})
                        err_count <= err_count + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Self-checking bench for imm_field_encoder: directed cases followed by random
// traffic, scored against an arithmetic model of the encoding rules.
module tb_imm_field_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_field;
    logic        out_type;
    logic        out_type2;
    logic        out_type3;
    logic        out_err;
    logic        err_sticky;
    logic        clr_stats;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    int          passed = 0;
    int          total  = 0;

    logic [23:0] exp_q[$];
    logic [15:0] m_enc;
    logic [7:0]  m_err;
    logic        m_sticky;
    logic [23:0] snap;
    logic        have_snap;
    logic [19:0] last_field;
    logic [2:0]  last_sel;
    logic        last_err;

    int bnd[18] = '{-2048, 2047, 2048, -2049, 0, 31, 32, -1, -4096, 4094, 4095,
                    -4098, -1048576, 1048574, 1048575, 1048576, -1048578, 32'h12345000};

    imm_field_encoder #(.CNT_W(16), .ERR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_field  (out_field),
        .out_type   (out_type),
        .out_type2  (out_type2),
        .out_type3  (out_type3),
        .out_err    (out_err),
        .err_sticky (err_sticky),
        .clr_stats  (clr_stats),
        .enc_count  (enc_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference encoding: returns {err, {type3,type2,type}, field}.
    function automatic logic [23:0] ref_enc(logic [2:0] fmt, logic [31:0] imm);
        longint      v;
        logic        ok;
        logic [2:0]  sel;
        logic [31:0] fld;
        v   = $signed(imm);
        ok  = 1'b0;
        sel = 3'd0;
        fld = 32'd0;
        case (fmt)
            3'd0, 3'd2: begin ok = (v >= -2048) && (v <= 2047); fld = imm & 32'hFFF; sel = 3'd0; end
            3'd1: begin ok = (v >= 0) && (v <= 31); fld = imm & 32'h1F; sel = 3'd1; end
            3'd3: begin ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
                        fld = (imm >> 1) & 32'hFFF; sel = 3'd2; end
            3'd4: begin ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
                        fld = (imm >> 1) & 32'hFFFFF; sel = 3'd3; end
            3'd5: begin ok = (imm % 4096 == 0); fld = imm >> 12; sel = 3'd4; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            fld = 32'd0;
            sel = 3'd0;
        end
        return {!ok, sel, fld[19:0]};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // One clock of stimulus; scores any output transfer and tracks the counters.
    task automatic apply_stimulus(input logic v, input logic [2:0] f, input logic [31:0] im,
                                  input logic ordy, input logic clr, output logic acc);
        logic [23:0] e;
        logic [23:0] cur;
        in_valid  = v;
        in_fmt    = f;
        in_imm    = im;
        out_ready = ordy;
        clr_stats = clr;
        @(negedge clk);
        acc = in_valid && in_ready;
        cur = {out_err, out_type3, out_type2, out_type, out_field};
        if (out_valid) begin
            if (have_snap) check_output("stall_hold", 32'(cur), 32'(snap));
            if (out_ready) begin
                have_snap = 1'b0;
                if (exp_q.size() == 0) begin
                    check_output("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("out_field", 32'(out_field), 32'(e[19:0]));
                    check_output("out_sel", 32'({out_type3, out_type2, out_type}), 32'(e[22:20]));
                    check_output("out_err", 32'(out_err), 32'(e[23]));
                    last_field = out_field;
                    last_sel   = {out_type3, out_type2, out_type};
                    last_err   = out_err;
                    if (!clr) begin
                        m_enc = m_enc + 16'd1;
                        if (e[23]) begin
                            m_sticky = 1'b1;
                            if (m_err != 8'hFF) m_err = m_err + 8'd1;
                        end
                    end
                end
            end else begin
                snap      = cur;
                have_snap = 1'b1;
            end
        end else begin
            have_snap = 1'b0;
        end
        if (clr) begin
            m_enc    = '0;
            m_err    = '0;
            m_sticky = 1'b0;
        end
        if (acc) exp_q.push_back(ref_enc(f, im));
        @(posedge clk);
        #1;
        check_output("enc_count", 32'(enc_count), 32'(m_enc));
        check_output("err_count", 32'(err_count), 32'(m_err));
        check_output("err_sticky", 32'(err_sticky), 32'(m_sticky));
    endtask

    task automatic run_item(input logic [2:0] f, input logic [31:0] im);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            apply_stimulus(1'b1, f, im, 1'b1, 1'b0, acc);
            n++;
        end
        if (!acc) check_output("accept_timeout", 32'(acc), 32'd1);
        repeat (2) apply_stimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, acc);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            apply_stimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, acc);
            n++;
        end
        check_output("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic acc;
        logic saw_block;
        int   sent;
        int   cyc;
        logic [31:0] rimm;

        reset = 1'b1; in_valid = 1'b0; in_fmt = '0; in_imm = '0;
        out_ready = 1'b0; clr_stats = 1'b0;
        m_enc = '0; m_err = '0; m_sticky = 1'b0; have_snap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_out_field", 32'(out_field), 32'd0);
        check_output("rst_out_err", 32'(out_err), 32'd0);
        check_output("rst_enc_count", 32'(enc_count), 32'd0);
        check_output("rst_err_sticky", 32'(err_sticky), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_output("rel_in_ready_high", 32'(in_ready), 32'd1);

        // Case 1: I, -1, with latency observed directly.
        apply_stimulus(1'b1, 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, acc);
        check_output("t1_accept", 32'(acc), 32'd1);
        check_output("t1_lat_n1", 32'(out_valid), 32'd0);
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, acc);
        check_output("t1_lat_n2", 32'(out_valid), 32'd1);
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, acc);
        check_output("t1_field", 32'(last_field), 32'h00FFF);
        check_output("t1_sel", 32'(last_sel), 32'd0);
        check_output("t1_err", 32'(last_err), 32'd0);

        // Case 2: B boundary values.
        run_item(3'd3, -32'sd4096);
        check_output("t2_field", 32'(last_field), 32'h00800);
        check_output("t2_sel", 32'(last_sel), 32'b010);
        run_item(3'd3, 32'd4095);
        check_output("t2_err", 32'(last_err), 32'd1);
        check_output("t2_err_field", 32'(last_field), 32'd0);
        check_output("t2_err_count", 32'(err_count), 32'd1);

        // Case 3: J and U.
        run_item(3'd4, 32'h0007_FFFE);
        check_output("t3_j_field", 32'(last_field), 32'h3FFFF);
        check_output("t3_j_sel", 32'(last_sel), 32'b011);
        run_item(3'd5, 32'h1234_5000);
        check_output("t3_u_field", 32'(last_field), 32'h12345);
        check_output("t3_u_sel", 32'(last_sel), 32'b100);

        // Case 4: back-to-back with a stall on cycles 3-5.
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b1, acc);
        sent = 0; cyc = 1; saw_block = 1'b0;
        while (sent < 8 && cyc < 40) begin
            apply_stimulus(1'b1, 3'(sent % 6), 32'(sent * 2), !(cyc >= 3 && cyc <= 5), 1'b0, acc);
            if (acc) sent++;
            else saw_block = 1'b1;
            cyc++;
        end
        drain();
        check_output("t4_sent", 32'(sent), 32'd8);
        check_output("t4_in_ready_low", 32'(saw_block), 32'd1);
        check_output("t4_enc_count", 32'(enc_count), 32'd8);

        // Case 5: SHAMT out of range, illegal format, clear racing an error.
        run_item(3'd1, 32'd32);
        check_output("t5_shamt_err", 32'(last_err), 32'd1);
        run_item(3'd7, 32'd0);
        check_output("t5_fmt7_err", 32'(last_err), 32'd1);
        check_output("t5_sticky", 32'(err_sticky), 32'd1);
        apply_stimulus(1'b1, 3'd6, 32'd0, 1'b1, 1'b0, acc);
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, acc);
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b1, acc);
        check_output("t5_clr_err_count", 32'(err_count), 32'd0);
        check_output("t5_clr_sticky", 32'(err_sticky), 32'd0);

        // err_count saturation.
        sent = 0; cyc = 0;
        while (sent < 260 && cyc < 600) begin
            apply_stimulus(1'b1, 3'd6, 32'(cyc), 1'b1, 1'b0, acc);
            if (acc) sent++;
            cyc++;
        end
        drain();
        check_output("sat_err_count", 32'(err_count), 32'hFF);
        check_output("sat_enc_count", 32'(enc_count), 32'd260);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rimm = $urandom;
                1:       rimm = 32'($signed(32'($urandom_range(0, 10000))) - 5000);
                2:       rimm = 32'(bnd[$urandom_range(0, 17)]);
                default: rimm = $urandom & 32'hFFFF_F000;
            endcase
            apply_stimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rimm,
                           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, acc);
        end
        drain();

        // Case 6: reset with both stages full.
        apply_stimulus(1'b1, 3'd0, 32'd5, 1'b0, 1'b0, acc);
        apply_stimulus(1'b1, 3'd0, 32'd6, 1'b0, 1'b0, acc);
        check_output("t6_full_valid", 32'(out_valid), 32'd1);
        check_output("t6_full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_output("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check_output("t6_rst_field", 32'(out_field), 32'd0);
        check_output("t6_rst_enc_count", 32'(enc_count), 32'd0);
        exp_q.delete();
        m_enc = '0; m_err = '0; m_sticky = 1'b0; have_snap = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, acc);
            check_output("t6_no_stale", 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
